board_keeper: RTL

Board-keeping and turn-sequencing block for the tic-tac-toe game. It accepts the player's square selection from a push-button strobe, validates it, and records it in the X board. It then requests a move from the computer move generator over a req/ack handshake, validates and records that reply in the O board, and declares win or draw. It sits between the switch/KEY top level and the move generator, and is the single owner of the `xs`/`os` board registers.

---
 rtl/ttt_pkg.sv | 33 +++
 rtl/key_edge_sync.sv | 28 ++
 rtl/board_keeper.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe types and board helpers.
// Squares are bit indices 0..8 of a 9-bit board vector.
package ttt_pkg;

    localparam int SQUARES = 9;

    typedef enum logic [2:0] {
        PLAYER_TURN,
        CHECK_X,
        BOT_WAIT,
        CHECK_O,
        WIN_X,
        WIN_O,
        DRAW,
        FAULT
    } gameState_t;

    function automatic logic line_win(input logic [8:0] board);
        return (&board[8:6]) | (&board[5:3]) | (&board[2:0]) |
               (board[8] & board[5] & board[2]) |
               (board[7] & board[4] & board[1]) |
               (board[6] & board[3] & board[0]) |
               (board[8] & board[4] & board[0]) |
               (board[6] & board[4] & board[2]);
    endfunction

    function automatic logic square_free(input logic [8:0] xs, input logic [8:0] os,
                                         input logic [3:0] idx);
        if (idx > 4'd8) return 1'b0;
        return ~(xs[idx] | os[idx]);
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer with rising-edge detect for a push-button level.
// Flops reset high so a key held through reset never produces an edge.
module key_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic keyLevel,
    output logic keyEdge
);

    logic key_s1;
    logic key_s2;
    logic key_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_prev <= 1'b1;
        end else begin
            key_s1   <= keyLevel;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    assign keyEdge = key_s2 & ~key_prev;

endmodule

// File: rtl/board_keeper.sv
// Turn sequencer and sole owner of the X/O board registers.
//   state       | meaning
//   PLAYER_TURN | waiting for a player key edge
//   CHECK_X     | evaluate win/draw after the X move
//   BOT_WAIT    | bot_req high, waiting for generator ack
//   CHECK_O     | evaluate win/draw after the O move
//   WIN_X/WIN_O | terminal, a line was completed
//   DRAW        | terminal, board full with no line
//   FAULT       | terminal, generator returned an illegal square
module board_keeper
    import ttt_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] move_square,
    input  logic       move_key,
    output logic       bot_req,
    input  logic       bot_ack,
    input  logic [3:0] bot_square,
    output logic [8:0] xs,
    output logic [8:0] os,
    output logic [3:0] move_count,
    output logic       player_won,
    output logic       computer_won,
    output logic       game_draw,
    output logic       illegal_move,
    output logic       bot_error
);

    gameState_t state, stateNext;
    logic [8:0] xsNext, osNext;
    logic [3:0] countNext;
    logic       playerWonNext, computerWonNext, drawNext, illegalNext, botErrorNext;
    logic       keyEdge;

    key_edge_sync keySync (
        .clock    (clock),
        .reset    (reset),
        .keyLevel (move_key),
        .keyEdge  (keyEdge)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= PLAYER_TURN;
            xs           <= '0;
            os           <= '0;
            move_count   <= '0;
            player_won   <= 1'b0;
            computer_won <= 1'b0;
            game_draw    <= 1'b0;
            illegal_move <= 1'b0;
            bot_error    <= 1'b0;
        end else begin
            state        <= stateNext;
            xs           <= xsNext;
            os           <= osNext;
            move_count   <= countNext;
            player_won   <= playerWonNext;
            computer_won <= computerWonNext;
            game_draw    <= drawNext;
            illegal_move <= illegalNext;
            bot_error    <= botErrorNext;
        end
    end

    always_comb begin
        stateNext       = state;
        xsNext          = xs;
        osNext          = os;
        countNext       = move_count;
        playerWonNext   = player_won;
        computerWonNext = computer_won;
        drawNext        = game_draw;
        illegalNext     = 1'b0;
        botErrorNext    = bot_error;
        case (state)
            PLAYER_TURN: begin
                if (keyEdge) begin
                    if (square_free(xs, os, move_square)) begin
                        xsNext    = xs | (9'd1 << move_square);
                        countNext = move_count + 4'd1;
                        stateNext = CHECK_X;
                    end else begin
                        illegalNext = 1'b1;
                    end
                end
            end
            CHECK_X: begin
                if (line_win(xs)) begin
                    stateNext     = WIN_X;
                    playerWonNext = 1'b1;
                end else if (move_count == 4'(SQUARES)) begin
                    stateNext = DRAW;
                    drawNext  = 1'b1;
                end else begin
                    stateNext = BOT_WAIT;
                end
            end
            // Key edges arriving here are dropped; only the generator reply matters.
            BOT_WAIT: begin
                if (bot_ack) begin
                    if (square_free(xs, os, bot_square)) begin
                        osNext    = os | (9'd1 << bot_square);
                        countNext = move_count + 4'd1;
                        stateNext = CHECK_O;
                    end else begin
                        botErrorNext = 1'b1;
                        stateNext    = FAULT;
                    end
                end
            end
            CHECK_O: begin
                if (line_win(os)) begin
                    stateNext       = WIN_O;
                    computerWonNext = 1'b1;
                end else if (move_count == 4'(SQUARES)) begin
                    stateNext = DRAW;
                    drawNext  = 1'b1;
                end else begin
                    stateNext = PLAYER_TURN;
                end
            end
            default: ;
        endcase
    end

    assign bot_req = (state == BOT_WAIT);

    boardsDisjoint: assert property (@(posedge clock) disable iff (reset)
        (xs & os) == 9'd0);
    countMatches: assert property (@(posedge clock) disable iff (reset)
        move_count == 4'($countones(xs) + $countones(os)));

endmodule
